// File: rtl/cache_pkg.sv
// Shared types and address-field constants for the direct-mapped read cache.
package cache_pkg;

    localparam int ADDR_BITS   = 32;
    localparam int OFFSET_BITS = 2;
    localparam int WORD_BITS   = ADDR_BITS - OFFSET_BITS;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        REFILL,
        RESPOND
    } state_t;

    function automatic int tag_bits(input int index_bits);
        return WORD_BITS - index_bits;
    endfunction

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/cache_line_store.sv
// Tag/valid/data storage: synchronous write, combinational read, bulk valid clear.
module cache_line_store
    import cache_pkg::*;
#(
    parameter int INDEX_BITS = 4,
    parameter int TAG_BITS   = tag_bits(INDEX_BITS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_all,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] index,
    input  logic [TAG_BITS-1:0]   wtag,
    input  logic [31:0]           wdata,
    output logic                  line_valid,
    output logic [TAG_BITS-1:0]   line_tag,
    output logic [31:0]           line_data
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]    valid_q;
    logic [LINES-1:0]    valid_d;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [31:0]         data_mem [LINES];

    always_comb begin
        valid_d = valid_q;
        if (clear_all) begin
            valid_d = '0;
        end else if (we) begin
            valid_d[index] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload arrays need no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_mem[index]  <= wtag;
            data_mem[index] <= wdata;
        end
    end

    assign line_valid = valid_q[index];
    assign line_tag   = tag_mem[index];
    assign line_data  = data_mem[index];

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped read-only cache controller with timed-out refill and
// saturating hit/miss statistics.
module dm_cache_ctrl
    import cache_pkg::*;
#(
    parameter int INDEX_BITS  = 4,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] address,
    input  logic        flush,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_data,
    output logic [31:0] hitCount,
    output logic [31:0] missCount
);

    localparam int TAG_W  = tag_bits(INDEX_BITS);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t               state_q, state_d;
    logic [WORD_BITS-1:0] addr_q, addr_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic                 mem_req_q, mem_req_d;
    logic [31:0]          mem_addr_q, mem_addr_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [31:0]          hit_q, hit_d;
    logic [31:0]          miss_q, miss_d;

    logic                  clear_all;
    logic                  line_we;
    logic                  line_valid;
    logic [TAG_W-1:0]      line_tag;
    logic [31:0]           line_data;
    logic [INDEX_BITS-1:0] idx;
    logic [TAG_W-1:0]      tag;
    logic                  lookup_hit;
    logic                  unused_offset;

    assign unused_offset = ^address[OFFSET_BITS-1:0];

    assign idx        = addr_q[INDEX_BITS-1:0];
    assign tag        = addr_q[WORD_BITS-1:INDEX_BITS];
    assign lookup_hit = line_valid && (line_tag == tag);
    assign clear_all  = (state_q == IDLE) && flush;
    assign line_we    = (state_q == REFILL) && mem_ack;

    cache_line_store #(
        .INDEX_BITS(INDEX_BITS),
        .TAG_BITS  (TAG_W)
    ) u_store (
        .clk       (clk),
        .reset     (reset),
        .clear_all (clear_all),
        .we        (line_we),
        .index     (idx),
        .wtag      (tag),
        .wdata     (mem_data),
        .line_valid(line_valid),
        .line_tag  (line_tag),
        .line_data (line_data)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        wait_d     = wait_q;
        hit_d      = hit_q;
        miss_d     = miss_q;
        unique case (state_q)
            IDLE: begin
                if (!flush && req_valid) begin
                    addr_d  = address[ADDR_BITS-1:OFFSET_BITS];
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (lookup_hit) begin
                    hit_d   = sat_inc(hit_q);
                    rdata_d = line_data;
                    state_d = RESPOND;
                end else begin
                    miss_d     = sat_inc(miss_q);
                    mem_req_d  = 1'b1;
                    mem_addr_d = {addr_q, {OFFSET_BITS{1'b0}}};
                    wait_d     = '0;
                    state_d    = REFILL;
                end
            end
            REFILL: begin
                if (mem_ack) begin
                    rdata_d   = mem_data;
                    mem_req_d = 1'b0;
                    state_d   = RESPOND;
                end else if (wait_q == WAIT_W'(MEM_TIMEOUT)) begin
                    rdata_d   = '0;
                    err_d     = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = RESPOND;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            RESPOND: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            wait_q     <= '0;
            hit_q      <= '0;
            miss_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            wait_q     <= wait_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
        end
    end

    assign req_ready  = (state_q == IDLE) && !flush;
    assign resp_valid = (state_q == RESPOND);
    assign resp_err   = err_q;
    assign rdata      = rdata_q;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign hitCount   = hit_q;
    assign missCount  = miss_q;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Scoreboard bench for dm_cache_ctrl with a delayed-ack memory responder.
module tb_dm_cache_ctrl;

    localparam int TMO = 255;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] address = '0;
    logic        flush = 1'b0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_data = '0;
    logic [31:0] hitCount;
    logic [31:0] missCount;

    dm_cache_ctrl #(.INDEX_BITS(4), .MEM_TIMEOUT(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .address   (address),
        .flush     (flush),
        .resp_valid(resp_valid),
        .resp_err  (resp_err),
        .rdata     (rdata),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_data  (mem_data),
        .hitCount  (hitCount),
        .missCount (missCount)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];

    bit          m_valid [16];
    logic [25:0] m_tag   [16];
    logic [31:0] m_data  [16];
    int          exp_hit = 0;
    int          exp_miss = 0;

    int          ack_delay = 3;
    bit          ack_en = 1'b1;
    bit          stray = 1'b0;
    int          ack_cnt = 0;
    int          resp_cnt = 0;
    int          memreq_cycles = 0;
    logic [31:0] last_maddr = '0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'd856) return 32'hDEAD_BEEF;
        return {a[15:0], 16'hC0DE};
    endfunction

    // Memory responder: acks ack_delay cycles after mem_req is seen.
    always @(negedge clk) begin
        mem_ack  = stray;
        mem_data = stray ? 32'h0BAD_0BAD : mem_data;
        if (mem_req) begin
            memreq_cycles++;
            last_maddr = mem_addr;
        end
        if (mem_req && ack_en) begin
            ack_cnt++;
            if (ack_cnt == ack_delay) begin
                mem_ack  = 1'b1;
                mem_data = memf(mem_addr);
                ack_cnt  = 0;
            end
        end else begin
            ack_cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (resp_valid) begin
            resp_cnt++;
            if (exp_q.size() == 0) begin
                chk("spurious_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rdata", rdata, e.data);
                chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
            end
        end
    end

    task automatic rd(input logic [31:0] a);
        int          idx;
        logic [25:0] tg;
        bit          hit;
        int          n;
        int          rb;
        int          mb;
        exp_t        e;
        idx = int'(a[5:2]);
        tg  = a[31:6];
        hit = m_valid[idx] && (m_tag[idx] == tg);
        if (hit) begin
            e = '{err: 1'b0, data: m_data[idx]};
            exp_hit++;
        end else if (ack_en) begin
            e = '{err: 1'b0, data: memf({a[31:2], 2'b00})};
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_data[idx]  = e.data;
            exp_miss++;
        end else begin
            e = '{err: 1'b1, data: 32'd0};
            exp_miss++;
        end
        exp_q.push_back(e);
        rb = resp_cnt;
        mb = memreq_cycles;
        @(negedge clk);
        address   = a;
        req_valid = 1'b1;
        #1;
        chk("req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        while (resp_cnt == rb && n < 600) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("resp_timeout", {31'd0, n < 600}, 32'd1);
        if (hit) begin
            chk("hit_latency", n, 2);
            chk("hit_no_memreq", memreq_cycles - mb, 0);
        end else begin
            chk("mem_addr", last_maddr, {a[31:2], 2'b00});
            if (!ack_en) begin
                chk("tmo_len", {31'd0, (memreq_cycles - mb) inside {TMO, TMO + 1}}, 32'd1);
            end
        end
        chk("hitCount", hitCount, exp_hit);
        chk("missCount", missCount, exp_miss);
    endtask

    initial begin
        int rb;
        int n;
        repeat (2) @(negedge clk);
        chk("rst_rdata", rdata, 0);
        chk("rst_hit", hitCount, 0);
        chk("rst_miss", missCount, 0);
        chk("rst_memreq", {31'd0, mem_req}, 0);
        chk("rst_maddr", mem_addr, 0);
        chk("rst_resp", {30'd0, resp_valid, resp_err}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_ready", {31'd0, req_ready}, 1);

        rd(32'd858);
        rd(32'd858);
        repeat (3) @(negedge clk);
        chk("rdata_hold", rdata, 32'hDEAD_BEEF);
        rd(32'd2233);
        rd(32'd858);
        rd(32'd922);
        rd(32'd858);
        chk("miss_total", missCount, 4);

        stray = 1'b1;
        repeat (2) @(negedge clk);
        stray = 1'b0;
        rd(32'd858);

        @(negedge clk);
        flush     = 1'b1;
        req_valid = 1'b1;
        address   = 32'd858;
        #1;
        chk("flush_ready", {31'd0, req_ready}, 0);
        rb = resp_cnt;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        repeat (4) @(negedge clk);
        chk("flush_no_resp", resp_cnt - rb, 0);
        rd(32'd858);

        ack_en = 1'b0;
        rd(32'd4000);
        ack_en = 1'b1;
        rd(32'd4000);

        ack_en = 1'b0;
        rb = resp_cnt;
        @(negedge clk);
        address   = 32'd3000;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("refill_start", {31'd0, mem_req}, 1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_async_memreq", {31'd0, mem_req}, 0);
        chk("rst_mid_hit", hitCount, 0);
        chk("rst_mid_miss", missCount, 0);
        @(negedge clk);
        reset = 1'b0;
        exp_hit  = 0;
        exp_miss = 0;
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        ack_en = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_no_resp", resp_cnt - rb, 0);
        rd(32'd858);
        rd(32'd858);
        chk("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dm_cache_ctrl.md
DM_CACHE_CTRL -- requirements
Module: dm_cache_ctrl

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 4, log2 of line count (16 lines).
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255, maximum cycles to wait for mem_ack before abort.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  requester presents a read address.
REQ-006 SHALL have port req_ready  output  1  controller accepts request this cycle.
REQ-007 SHALL have port address  input  32  byte read address: offset [1:0] ignored, index [INDEX_BITS+1:2], tag [31:INDEX_BITS+2].
REQ-008 SHALL have port flush  input  1  invalidate all lines.
REQ-009 SHALL have port resp_valid  output  1  one-cycle pulse: rdata valid.
REQ-010 SHALL have port resp_err  output  1  qualifies resp_valid: refill timed out, rdata = 0.
REQ-011 SHALL have port rdata  output  32  read data.
REQ-012 SHALL have port mem_req  output  1  refill request, held until mem_ack or timeout.
REQ-013 SHALL have port mem_addr  output  32  word-aligned refill address ({tag,index,2'b00}).
REQ-014 SHALL have port mem_ack  input  1  memory returns mem_data this cycle.
REQ-015 SHALL have port mem_data  input  32  refill word.
REQ-016 SHALL have ports hitCount and missCount  output  32 each  access statistics.

Function
REQ-017 SHALL implement FSM states IDLE, LOOKUP, REFILL, RESPOND; req_ready=1 only in IDLE with flush=0.
REQ-018 IDLE: on req_valid && req_ready, SHALL register address and go LOOKUP; otherwise stay.
REQ-019 IDLE with flush=1 SHALL clear all valid bits in that cycle and ignore req_valid (flush has priority); flush outside IDLE SHALL be ignored.
REQ-020 LOOKUP: hit (valid && tag match) SHALL increment hitCount, load rdata from the data array, go RESPOND.
REQ-021 LOOKUP: miss SHALL increment missCount, assert mem_req with mem_addr, clear wait counter, go REFILL.
REQ-022 REFILL: on mem_ack SHALL write valid=1, tag, mem_data into the indexed line, set rdata=mem_data, deassert mem_req, go RESPOND.
REQ-023 REFILL: when wait counter reaches MEM_TIMEOUT without mem_ack, SHALL deassert mem_req, leave line unchanged, set resp_err=1, rdata=0, go RESPOND.
REQ-024 RESPOND: SHALL assert resp_valid for exactly one cycle, then go IDLE; resp_err cleared on return to IDLE.
REQ-025 Hit latency SHALL be 2 cycles from accept edge to resp_valid; miss latency SHALL be 2 + cycles until mem_ack + 1.
REQ-026 mem_ack outside REFILL SHALL be ignored.
REQ-027 hitCount/missCount SHALL saturate at 0xFFFFFFFF, never wrap.
REQ-028 Conflicting tag on same index SHALL replace the line (direct-mapped, no write-back; read-only cache).
REQ-029 rdata SHALL hold its last value outside RESPOND.

Reset
REQ-030 reset SHALL force IDLE, clear all valid bits, hitCount=0, missCount=0, rdata=0, resp_valid=0, resp_err=0, mem_req=0, mem_addr=0, wait counter=0.
REQ-031 reset asserted mid-REFILL SHALL drop mem_req immediately (asynchronously) and discard the pending request without response.

Structure
REQ-032 FSM state encoding, OFFSET_BITS=2 and address-field width constants SHALL live in shared package cache_pkg.
REQ-033 Tag/valid/data storage SHALL be one sub-module cache_line_store (sync write, combinational read, bulk valid clear).

Verification
REQ-034 Reset, then read 858 with mem_ack 3 cycles after mem_req, mem_data=0xDEADBEEF -> mem_addr=856, resp_valid with rdata=0xDEADBEEF, missCount=1.
REQ-035 Then read 858 again -> resp_valid 2 cycles after accept, rdata=0xDEADBEEF, no mem_req, hitCount=1.
REQ-036 Read 2233 (index 14) then 858 -> miss then hit; read 922 (index 6, new tag) then 858 -> two misses, missCount=4.
REQ-037 flush in IDLE concurrent with req_valid -> req_ready=0 that cycle; subsequent read 858 misses.
REQ-038 mem_ack withheld -> mem_req drops after MEM_TIMEOUT cycles, resp_valid with resp_err=1, rdata=0; retry of same address misses again.
REQ-039 reset asserted during REFILL -> mem_req=0 immediately, no resp_valid, counters=0, next request accepted normally.
